// File: rtl/twiddle_seq_if.sv
// Twiddle output stream between the sequencer and the butterfly engine.
//
// Handshake: an element transfers on a rising clk edge where tw_valid and
// tw_ready are both 1. Once tw_valid is raised, tw_re/tw_im/tw_idx and
// tw_valid itself hold steady until that transfer happens. tw_ready may be
// raised or lowered freely and does not depend on tw_valid.
interface twiddle_seq_if #(
  parameter int LOG2N = 3,
  parameter int TW_W  = 18
) ();
  logic                    tw_valid;
  logic                    tw_ready;
  logic signed [TW_W-1:0]  tw_re;
  logic signed [TW_W-1:0]  tw_im;
  logic [LOG2N-1:0]        tw_idx;

  modport master (
    output tw_valid,
    output tw_re,
    output tw_im,
    output tw_idx,
    input  tw_ready
  );

  modport slave (
    input  tw_valid,
    input  tw_re,
    input  tw_im,
    input  tw_idx,
    output tw_ready
  );
endinterface

// File: rtl/twiddle_seq.sv
// Twiddle-factor sequencer for an N = 2^LOG2N point FFT.
// Only the quarter-wave cosine table C[0..N/4] is stored; W_N^m is rebuilt
// from quadrant symmetry. A start pulse launches a strided index walk that
// streams one twiddle per cycle through a two-stage pipeline:
//   stage A: index counter register (a_valid / a_m)
//   stage B: table lookup + quadrant mux/negate, registered into tw_*
// Both stages advance together on en = !tw_valid || tw_ready.
module twiddle_seq #(
  parameter int LOG2N = 3,
  parameter int TW_W  = 18,
  parameter int FRAC  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LOG2N-1:0] stride,
  input  logic [LOG2N:0]   count,
  input  logic             inv,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg,
  twiddle_seq_if.master    tw
);

  localparam int N  = 1 << LOG2N;
  localparam int QN = N / 4;
  // Width able to hold table indices 0..QN inclusive.
  localparam int QW = LOG2N - 1;

  // Rounded (half away from zero) cos(2*pi*i/N) scaled by 2^FRAC.
  function automatic logic signed [TW_W-1:0] cos_entry(input int i);
    real ang;
    real scaled;
    ang    = 2.0 * 3.14159265358979323846 * real'(i) / real'(N);
    scaled = $cos(ang) * (2.0 ** real'(FRAC));
    if (scaled >= 0.0) begin
      return TW_W'($rtoi(scaled + 0.5));
    end else begin
      return TW_W'($rtoi(scaled - 0.5));
    end
  endfunction

  // Quarter-wave table, fixed at elaboration.
  logic signed [TW_W-1:0] cos_tab [0:QN];

  for (genvar g = 0; g <= QN; g++) begin : g_tab
    localparam logic signed [TW_W-1:0] C_VAL = cos_entry(g);
    assign cos_tab[g] = C_VAL;
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Parameters captured on the accepted start.
  logic [LOG2N-1:0] cfg_stride;
  logic [LOG2N:0]   cfg_count;
  logic             cfg_inv;

  // Stage A: next index to issue, elements issued so far, issued element.
  logic [LOG2N-1:0] next_m;
  logic [LOG2N:0]   issued;
  logic             a_valid;
  logic [LOG2N-1:0] a_m;

  logic en;
  logic load_cfg;
  logic issue;
  logic finish;

  assign en        = !tw.tw_valid || tw.tw_ready;
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

  // FSM next-state: IDLE waits for start, RUN issues count indices,
  // DRAIN waits until the last element has left stage B.
  always_comb begin
    state_d  = state_q;
    load_cfg = 1'b0;
    issue    = 1'b0;
    finish   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          load_cfg = 1'b1;
          // count = 0 skips straight to DRAIN, which completes at once.
          state_d  = (count == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (en) begin
          issue = 1'b1;
          if (issued == cfg_count - (LOG2N+1)'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Stage A empty and stage B either empty or handing off now.
        if (en && !a_valid) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Parameter capture and stage A index counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_stride <= '0;
      cfg_count  <= '0;
      cfg_inv    <= 1'b0;
      next_m     <= '0;
      issued     <= '0;
      a_valid    <= 1'b0;
      a_m        <= '0;
    end else begin
      if (load_cfg) begin
        cfg_stride <= stride;
        cfg_count  <= count;
        cfg_inv    <= inv;
        next_m     <= '0;
        issued     <= '0;
      end
      if (en) begin
        a_valid <= issue;
        if (issue) begin
          a_m    <= next_m;
          // Modulo-N wrap is plain truncation to LOG2N bits.
          next_m <= next_m + cfg_stride;
          issued <= issued + (LOG2N+1)'(1);
        end
      end
    end
  end

  logic [1:0]             quad;
  logic [QW-1:0]          r_idx;
  logic [QW-1:0]          rc_idx;
  logic signed [TW_W-1:0] c_r;
  logic signed [TW_W-1:0] c_rc;
  logic signed [TW_W-1:0] re_d;
  logic signed [TW_W-1:0] im_fwd;
  logic signed [TW_W-1:0] im_d;

  // Stage B combinational: quadrant symmetry applied to the two table reads.
  always_comb begin
    quad   = a_m[LOG2N-1 -: 2];
    r_idx  = QW'(a_m[LOG2N-3:0]);
    rc_idx = QW'(QN) - r_idx;
    c_r    = cos_tab[r_idx];
    c_rc   = cos_tab[rc_idx];
    re_d   = c_r;
    im_fwd = -c_rc;
    unique case (quad)
      2'd0: begin
        re_d   = c_r;
        im_fwd = -c_rc;
      end
      2'd1: begin
        re_d   = -c_rc;
        im_fwd = -c_r;
      end
      2'd2: begin
        re_d   = -c_r;
        im_fwd = c_rc;
      end
      default: begin
        re_d   = c_rc;
        im_fwd = c_r;
      end
    endcase
    // Two's complement negate keeps zero at zero.
    im_d = cfg_inv ? -im_fwd : im_fwd;
  end

  // Stage B output register; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tw.tw_valid <= 1'b0;
      tw.tw_re    <= '0;
      tw.tw_im    <= '0;
      tw.tw_idx   <= '0;
    end else if (en) begin
      tw.tw_valid <= a_valid;
      if (a_valid) begin
        tw.tw_re  <= re_d;
        tw.tw_im  <= im_d;
        tw.tw_idx <= a_m;
      end
    end
  end

  // Completion pulse, one cycle after the final handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= finish;
    end
  end

endmodule

// File: tb/tb_twiddle_seq.sv
// Bench for twiddle_seq: an N=8 instance driven from a vector table and an
// N=64 instance for the larger-size, ignored-start and count=0 cases.
`timescale 1ns/1ps
module tb_twiddle_seq;
  localparam int TW_W = 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- DUT N=8 ----------------
  logic       start8 = 1'b0;
  logic [2:0] stride8 = '0;
  logic [3:0] count8 = '0;
  logic       inv8 = 1'b0;
  logic       ready8 = 1'b1;
  logic       busy8, done8;
  logic [1:0] st8;

  twiddle_seq_if #(.LOG2N(3), .TW_W(TW_W)) if8 ();
  assign if8.tw_ready = ready8;

  twiddle_seq #(.LOG2N(3), .TW_W(TW_W), .FRAC(10)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .stride(stride8), .count(count8),
    .inv(inv8), .busy(busy8), .done(done8), .state_dbg(st8), .tw(if8)
  );

  // ---------------- DUT N=64 ----------------
  logic       start64 = 1'b0;
  logic [5:0] stride64 = '0;
  logic [6:0] count64 = '0;
  logic       inv64 = 1'b0;
  logic       ready64 = 1'b1;
  logic       busy64, done64;
  logic [1:0] st64;

  twiddle_seq_if #(.LOG2N(6), .TW_W(TW_W)) if64 ();
  assign if64.tw_ready = ready64;

  twiddle_seq #(.LOG2N(6), .TW_W(TW_W), .FRAC(10)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .stride(stride64), .count(count64),
    .inv(inv64), .busy(busy64), .done(done64), .state_dbg(st64), .tw(if64)
  );

  // Forward twiddles W_8^m scaled by 1024, m = 0..7.
  int ref_re [8] = '{1024, 724, 0, -724, -1024, -724, 0, 724};
  int ref_im [8] = '{0, -724, -1024, -724, 0, 724, 1024, 724};

  // ---------------- scoreboard ----------------
  logic [38:0] exp8_q[$];
  logic [41:0] exp64_q[$];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- monitor N=8 ----------------
  int  hs8 = 0, done8_n = 0, valid8_n = 0, last_hs8 = 0, t_start8 = 0, seq_cnt8 = 0;
  bit  first8 = 0;
  bit  p_v8 = 0, p_r8 = 0;
  logic signed [TW_W-1:0] p_re8, p_im8;
  logic [2:0] p_idx8;

  always @(negedge clk) begin
    logic [38:0] e;
    if (rst) begin
      p_v8 = 0;
    end else begin
      if (p_v8 && !p_r8) begin
        check("hold_valid8", if8.tw_valid, 1);
        check("hold_re8", if8.tw_re, p_re8);
        check("hold_im8", if8.tw_im, p_im8);
        check("hold_idx8", if8.tw_idx, p_idx8);
      end
      if (if8.tw_valid) valid8_n++;
      if (if8.tw_valid && first8) begin
        check("latency8", cyc - t_start8, 2);
        first8 = 0;
      end
      if (if8.tw_valid && ready8) begin
        if (exp8_q.size() == 0) begin
          fail_now("unexpected_out8");
        end else begin
          e = exp8_q.pop_front();
          check("idx8", if8.tw_idx, e[38:36]);
          check("re8", if8.tw_re, $signed(e[35:18]));
          check("im8", if8.tw_im, $signed(e[17:0]));
        end
        hs8++;
        last_hs8 = cyc;
      end
      if (done8) begin
        done8_n++;
        check("done_busy8", busy8, 0);
        if (seq_cnt8 == 0) check("done_t1_8", cyc - t_start8, 1);
        else check("done_after_hs8", cyc - last_hs8, 1);
      end
      p_v8 = if8.tw_valid;
      p_r8 = ready8;
      p_re8 = if8.tw_re;
      p_im8 = if8.tw_im;
      p_idx8 = if8.tw_idx;
    end
  end

  // ---------------- monitor N=64 ----------------
  int hs64 = 0, done64_n = 0, valid64_n = 0, last_hs64 = 0, t_start64 = 0, seq_cnt64 = 0;
  bit first64 = 0;

  always @(negedge clk) begin
    logic [41:0] e;
    if (!rst) begin
      if (if64.tw_valid) valid64_n++;
      if (if64.tw_valid && first64) begin
        check("latency64", cyc - t_start64, 2);
        first64 = 0;
      end
      if (if64.tw_valid && ready64) begin
        if (exp64_q.size() == 0) begin
          fail_now("unexpected_out64");
        end else begin
          e = exp64_q.pop_front();
          check("idx64", if64.tw_idx, e[41:36]);
          check("re64", if64.tw_re, $signed(e[35:18]));
          check("im64", if64.tw_im, $signed(e[17:0]));
        end
        hs64++;
        last_hs64 = cyc;
      end
      if (done64) begin
        done64_n++;
        check("done_busy64", busy64, 0);
        if (seq_cnt64 == 0) check("done_t1_64", cyc - t_start64, 1);
        else check("done_after_hs64", cyc - last_hs64, 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push8(input int stride, input int count, input int inv);
    logic [2:0] m;
    logic signed [17:0] er, ei;
    for (int k = 0; k < count; k++) begin
      m  = 3'((k * stride) % 8);
      er = 18'(ref_re[m]);
      ei = 18'((inv != 0) ? -ref_im[m] : ref_im[m]);
      exp8_q.push_back({m, er, ei});
    end
    hs8 = 0; done8_n = 0; valid8_n = 0;
    first8 = (count > 0);
    seq_cnt8 = count;
  endtask

  // Pulse start for one cycle, then scramble the inputs so only the
  // values captured at the accepted start can produce the right stream.
  task automatic pulse8(input int stride, input int count, input int inv);
    @(posedge clk); #1;
    start8 = 1'b1; stride8 = 3'(stride); count8 = 4'(count); inv8 = (inv != 0);
    @(posedge clk); #1;
    start8 = 1'b0; t_start8 = cyc;
    stride8 = 3'($urandom_range(0, 7));
    count8 = 4'($urandom_range(0, 15));
    inv8 = ~inv8;
  endtask

  task automatic run8(input int stride, input int count, input int inv,
                      input int stall_at, input int stall_len, input int rnd);
    int c;
    logic [2:0] m;
    push8(stride, count, inv);
    pulse8(stride, count, inv);
    if (count == 0) check("busy_pulse8", busy8, 1);
    c = 0;
    while (done8_n == 0 && c < 400) begin
      @(posedge clk); #1; c++;
      if (rnd != 0) begin
        ready8 = ($urandom_range(0, 3) != 0);
      end else if (stall_len > 0) begin
        ready8 = !(c >= stall_at + 2 && c < stall_at + 2 + stall_len);
        if (c == stall_at + 2) begin
          @(negedge clk);
          m = 3'((stall_at * stride) % 8);
          check("stall_valid8", if8.tw_valid, 1);
          check("stall_idx8", if8.tw_idx, m);
          check("stall_re8", if8.tw_re, ref_re[m]);
          check("stall_im8", if8.tw_im, ref_im[m]);
        end
      end
    end
    ready8 = 1'b1;
    if (done8_n == 0) fail_now("timeout8");
    @(negedge clk);
    check("hs_count8", hs8, count);
    check("done_once8", done8_n, 1);
    check("queue_empty8", exp8_q.size(), 0);
    check("idle_valid8", if8.tw_valid, 0);
    check("idle_busy8", busy8, 0);
    if (count == 0) check("no_valid8", valid8_n, 0);
    exp8_q.delete();
  endtask

  task automatic run64(input int stride, input int count, input int inv, input int mid);
    int c;
    logic [5:0] m;
    logic signed [17:0] er, ei;
    for (int k = 0; k < count; k++) begin
      m  = 6'((k * stride) % 64);
      er = 18'(ref_re[m[5:3]]);
      ei = 18'((inv != 0) ? -ref_im[m[5:3]] : ref_im[m[5:3]]);
      exp64_q.push_back({m, er, ei});
    end
    hs64 = 0; done64_n = 0; valid64_n = 0;
    first64 = (count > 0);
    seq_cnt64 = count;
    @(posedge clk); #1;
    start64 = 1'b1; stride64 = 6'(stride); count64 = 7'(count); inv64 = (inv != 0);
    @(posedge clk); #1;
    start64 = 1'b0; t_start64 = cyc;
    if (count == 0) check("busy_pulse64", busy64, 1);
    c = 0;
    while (done64_n == 0 && c < 400) begin
      @(posedge clk); #1; c++;
      start64 = 1'b0;
      if (mid != 0 && c == 3) begin
        // Different parameters while busy: must be ignored entirely.
        start64 = 1'b1; stride64 = 6'd1; count64 = 7'd3; inv64 = ~inv64;
      end
    end
    start64 = 1'b0;
    if (done64_n == 0) fail_now("timeout64");
    @(negedge clk);
    check("hs_count64", hs64, count);
    check("done_once64", done64_n, 1);
    check("queue_empty64", exp64_q.size(), 0);
    check("idle_busy64", busy64, 0);
    if (count == 0) check("no_valid64", valid64_n, 0);
    exp64_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int stride;
    int count;
    int inv;
    int stall_at;
    int stall_len;
    int rnd;
  } vec_t;

  vec_t vecs [9];

  // Safety net in case the DUT never settles.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    vecs[0] = '{stride: 1, count: 8,  inv: 0, stall_at: 0, stall_len: 0, rnd: 0};
    vecs[1] = '{stride: 1, count: 8,  inv: 1, stall_at: 0, stall_len: 0, rnd: 0};
    vecs[2] = '{stride: 3, count: 4,  inv: 0, stall_at: 0, stall_len: 0, rnd: 0};
    vecs[3] = '{stride: 1, count: 8,  inv: 0, stall_at: 1, stall_len: 3, rnd: 0};
    vecs[4] = '{stride: 5, count: 12, inv: 1, stall_at: 0, stall_len: 0, rnd: 1};
    vecs[5] = '{stride: 1, count: 0,  inv: 0, stall_at: 0, stall_len: 0, rnd: 0};
    vecs[6] = '{stride: 7, count: 15, inv: 0, stall_at: 0, stall_len: 0, rnd: 1};
    vecs[7] = '{stride: int'($urandom_range(0, 7)), count: int'($urandom_range(1, 15)),
                inv: int'($urandom_range(0, 1)), stall_at: 0, stall_len: 0, rnd: 1};
    vecs[8] = '{stride: int'($urandom_range(0, 7)), count: int'($urandom_range(1, 15)),
                inv: int'($urandom_range(0, 1)), stall_at: 0, stall_len: 0, rnd: 0};

    // Reset state, during and after reset.
    @(negedge clk);
    check("rst_valid8", if8.tw_valid, 0);
    check("rst_re8", if8.tw_re, 0);
    check("rst_im8", if8.tw_im, 0);
    check("rst_idx8", if8.tw_idx, 0);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_valid64", if64.tw_valid, 0);
    check("rst_busy64", busy64, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_state8", st8, 0);
    check("idle_valid_after_rst8", if8.tw_valid, 0);

    for (int i = 0; i < 9; i++) begin
      run8(vecs[i].stride, vecs[i].count, vecs[i].inv,
           vecs[i].stall_at, vecs[i].stall_len, vecs[i].rnd);
    end

    // Larger size: stride 8 walks the same eight angles.
    run64(8, 8, 0, 1);
    run64(8, 0, 0, 0);
    run64(24, 10, 1, 0);

    // Asynchronous reset mid-sequence.
    push8(1, 8, 0);
    pulse8(1, 8, 0);
    c = 0;
    while (hs8 < 3 && c < 50) begin
      @(negedge clk); c++;
    end
    if (hs8 < 3) fail_now("abort_wait8");
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("abort_valid8", if8.tw_valid, 0);
    check("abort_re8", if8.tw_re, 0);
    check("abort_im8", if8.tw_im, 0);
    check("abort_idx8", if8.tw_idx, 0);
    check("abort_busy8", busy8, 0);
    check("abort_done8", done8, 0);
    exp8_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done8", done8_n, 0);
    check("abort_idle8", busy8, 0);

    // Full sequence after the abort.
    run8(1, 8, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
